// File: rtl/soc_ctrl_clk_rst_seq.sv
// Power-domain clock/reset sequencer: orders clock enable and reset release on
// power-up, and clock gating then reset assertion on power-down.
module soc_ctrl_clk_rst_seq #(
    parameter int unsigned DELAY_CYCLES = 50
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic req_valid_i,
    input  logic req_on_i,
    output logic req_ready_o,
    output logic done_o,
    output logic status_on_o,
    output logic arst_no,
    output logic clk_en_o
);

    localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        UP_CLK = 3'd1,
        UP_RST = 3'd2,
        ON     = 3'd3,
        DN_CLK = 3'd4,
        DN_RST = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          done_d;
    logic          clk_en_d, rst_n_d, ready_d, status_d;

    assign accept = req_valid_i && req_ready_o;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            OFF: begin
                if (accept) begin
                    if (req_on_i) begin
                        state_d = UP_CLK;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ON: begin
                if (accept) begin
                    if (!req_on_i) begin
                        state_d = DN_CLK;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            UP_CLK, DN_CLK: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == UP_CLK) ? UP_RST : DN_RST;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UP_RST, DN_RST: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == UP_RST) ? ON : OFF;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        clk_en_d = (state_d == UP_CLK) || (state_d == UP_RST) || (state_d == ON);
        rst_n_d  = (state_d == UP_RST) || (state_d == ON) || (state_d == DN_CLK);
        ready_d  = (state_d == OFF) || (state_d == ON);
        status_d = (state_d == ON);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            done_o      <= 1'b0;
            clk_en_o    <= 1'b0;
            arst_no     <= 1'b0;
            req_ready_o <= 1'b1;
            status_on_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_o      <= done_d;
            clk_en_o    <= clk_en_d;
            arst_no     <= rst_n_d;
            req_ready_o <= ready_d;
            status_on_o <= status_d;
        end
    end

endmodule

// File: doc/soc_ctrl_clk_rst_seq.md
SOC_CTRL_CLK_RST_SEQ -- requirements
Module: soc_ctrl_clk_rst_seq

Interface
REQ-001 SHALL have parameter: DELAY_CYCLES, default 50, number of clk_i cycles spent in each sequencing wait phase; legal range 1..65535.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: arst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req_valid_i  input  1  power-state request valid.
REQ-005 SHALL have port: req_on_i  input  1  requested state: 1 = domain on, 0 = domain off; sampled only when req_valid_i && req_ready_o.
REQ-006 SHALL have port: req_ready_o  output  1  sequencer idle and able to accept a request.
REQ-007 SHALL have port: done_o  output  1  one-cycle pulse when an accepted request completes.
REQ-008 SHALL have port: status_on_o  output  1  domain fully on (clock enabled, reset released).
REQ-009 SHALL have port: arst_no  output  1  active-low domain reset, driven into the downstream clock/reset delay generator arst_ni.
REQ-010 SHALL have port: clk_en_o  output  1  domain clock enable, driven into the downstream delay generator clk_en_i.

Function
REQ-011 SHALL implement FSM states OFF, UP_CLK, UP_RST, ON, DN_CLK, DN_RST, all outputs registered.
REQ-012 SHALL drive per state (clk_en_o, arst_no): OFF (0,0); UP_CLK (1,0); UP_RST (1,1); ON (1,1); DN_CLK (0,1); DN_RST (0,0).
REQ-013 SHALL assert req_ready_o only in OFF and ON; a request is accepted on a rising edge where req_valid_i && req_ready_o.
REQ-014 SHALL, on accept in OFF with req_on_i=1, enter UP_CLK; in ON with req_on_i=0, enter DN_CLK.
REQ-015 SHALL, on accept of a request matching the current state (OFF/0 or ON/1), remain in that state and pulse done_o in the following cycle.
REQ-016 SHALL use a down-counter of width $clog2(DELAY_CYCLES+1), loaded with DELAY_CYCLES-1 on entry to any wait state (UP_CLK, UP_RST, DN_CLK, DN_RST), decremented each cycle, transition taken on the edge where count == 0; each wait state therefore lasts exactly DELAY_CYCLES cycles.
REQ-017 SHALL transition UP_CLK -> UP_RST -> ON and DN_CLK -> DN_RST -> OFF on counter expiry.
REQ-018 SHALL, for request accepted at edge k, reach ON (or OFF) at edge k+2*DELAY_CYCLES, assert done_o for exactly the cycle following that edge, and reassert req_ready_o in that same cycle.
REQ-019 SHALL set status_on_o = 1 only in state ON.
REQ-020 SHALL ignore req_valid_i while req_ready_o = 0; no request queuing.
REQ-021 SHALL never assert clk_en_o = 0 with arst_no = 1 except in DN_CLK, and never change clk_en_o and arst_no on the same edge.
REQ-022 SHALL return to OFF from any unencoded state on the next edge.

Reset
REQ-023 SHALL, on a rising edge with arst_ni = 0, enter OFF with clk_en_o = 0, arst_no = 0, req_ready_o = 1, done_o = 0, status_on_o = 0, counter = 0, regardless of current state.
REQ-024 SHALL, if reset occurs mid-sequence, abort the sequence with no done_o pulse.
REQ-025 SHALL accept a request on the first edge after arst_ni returns to 1.

Verification (DELAY_CYCLES = 4)
REQ-026 SHALL verify power-up: reset released, req_valid_i=1, req_on_i=1 at edge k -> clk_en_o=1 from k, arst_no=1 from k+4, status_on_o=1 and done_o=1 for one cycle from k+8, req_ready_o=0 for cycles k..k+7.
REQ-027 SHALL verify power-down from ON: req_on_i=0 accepted at edge k -> clk_en_o=0 from k, arst_no=0 from k+4, OFF with done_o pulse from k+8, status_on_o=0 from k.
REQ-028 SHALL verify redundant request: in OFF, req_on_i=0 accepted -> no output change except done_o=1 one cycle later.
REQ-029 SHALL verify requests held valid during UP_RST -> not accepted, sequence timing unchanged, accepted on first ON cycle.
REQ-030 SHALL verify reset mid-UP_RST (arst_ni=0 at edge k+5) -> clk_en_o=0, arst_no=0 from k+5, no done_o pulse.
REQ-031 SHALL verify DELAY_CYCLES=1 -> each wait phase lasts 1 cycle, done_o 2 cycles after accept.
